// File: rtl/krake_port_rx.sv
// Wishbone-slave 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM,
// single-byte data register with valid/overrun/framing/busy status and level IRQ.
module krake_port_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned RX_CH        = 1,
    parameter logic [4:0]  ADR_STATUS   = 5'd0,
    parameter logic [4:0]  ADR_DATA     = 5'd1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [4:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    input  logic [5:0] ch_in,
    output logic [5:0] ch_out,
    output logic [5:0] ch_oe,
    output logic       irq_o
);

    localparam logic [15:0] HalfCmp = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FullCmp = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBrk
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic        ferr_q, ferr_d;
    logic        ack_q, ack_d;
    logic [7:0]  dat_o_q, dat_o_d;

    logic        line;
    logic        half_hit;
    logic        full_hit;
    logic        frame_good;
    logic        frame_bad;
    logic        busy;
    logic        rd_stb;
    logic        wr_stb;
    logic        data_rd;
    logic        status_wr;
    logic [7:0]  status_val;
    logic [7:0]  rdata;
    logic        unused_pins;

    assign line     = sync2_q;
    assign half_hit = (cnt_q == HalfCmp);
    assign full_hit = (cnt_q == FullCmp);
    assign busy     = (state_q != StIdle);

    // Sync flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ch_in[RX_CH];
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!line) state_d = StStart;
            end
            StStart: begin
                if (half_hit) state_d = line ? StIdle : StData;
            end
            StData: begin
                if (full_hit && (idx_q == 3'd7)) state_d = StStop;
            end
            StStop: begin
                if (full_hit) state_d = line ? StIdle : StBrk;
            end
            StBrk: begin
                if (line) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = 16'd0;
            end
            StStart: begin
                if (half_hit) begin
                    cnt_d = 16'd0;
                    idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (full_hit) begin
                    shift_d[idx_q] = line;
                    cnt_d          = 16'd0;
                    idx_d          = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (full_hit) begin
                    cnt_d      = 16'd0;
                    frame_good = line;
                    frame_bad  = !line;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StBrk: begin
                cnt_d = 16'd0;
            end
            default: cnt_d = 16'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign rd_stb     = stb_i && !we_i;
    assign wr_stb     = stb_i && we_i;
    assign data_rd    = rd_stb && (adr_i == ADR_DATA);
    assign status_wr  = wr_stb && (adr_i == ADR_STATUS);
    assign status_val = {4'b0000, busy, ferr_q, ovr_q, valid_q};

    always_comb begin
        rdata = 8'h00;
        if (adr_i == ADR_STATUS) begin
            rdata = status_val;
        end else if (adr_i == ADR_DATA) begin
            rdata = data_q;
        end
    end

    assign ack_d   = stb_i;
    assign dat_o_d = rd_stb ? rdata : dat_o_q;

    // Flag sets are applied last so they win over a same-cycle clear.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = ferr_q;
        if (status_wr) begin
            if (dat_i[2]) ferr_d = 1'b0;
            if (dat_i[1]) ovr_d = 1'b0;
        end
        if (data_rd) valid_d = 1'b0;
        if (frame_good) begin
            if (!valid_q || data_rd) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (frame_bad) ferr_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_o_q <= 8'h00;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            ack_q   <= ack_d;
            dat_o_q <= dat_o_d;
        end
    end

    assign dat_o  = dat_o_q;
    assign ack_o  = ack_q;
    assign irq_o  = valid_q || ferr_q || ovr_q;
    assign ch_out = 6'h00;
    assign ch_oe  = 6'h00;

    assign unused_pins = ^{dat_i[7:3], dat_i[0], ch_in};

endmodule

// File: doc/krake_port_rx.md
Name: krake_port_rx

Overview:
- Wishbone-slave UART receiver peripheral. It is the receive-side counterpart of the krake_port_tx2 UART transmitter, and uses the same register-bus and channel-pin interface.
- It samples one channel pin, deserialises 8N1 frames (LSB first) and holds the received byte in a data register. The CPU reads that register over Wishbone.
- Status flags report data-valid, overrun, framing error and receiver-busy.

Parameters:
- CLKS_PER_BIT, 434, system clocks per UART bit (50 MHz / 115200). Legal range 4..65535.
- RX_CH, 1, index into ch_in[5:0] used as the RX line.
- ADR_STATUS, 5'd0, Wishbone address of the status register.
- ADR_DATA, 5'd1, Wishbone address of the receive data register.

Ports:
- clk_i  in  1  system clock, 50 MHz.
- rst_i  in  1  reset, asynchronous, active-low.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  Wishbone write enable.
- adr_i  in  5  Wishbone address.
- dat_i  in  8  Wishbone write data.
- dat_o  out  8  Wishbone read data.
- ack_o  out  1  Wishbone acknowledge.
- ch_in  in  6  channel pins; ch_in[RX_CH] is the RX line.
- ch_out  out  6  channel output values; tied to 0.
- ch_oe  out  6  channel output enables; tied to 0 (all pins inputs).
- irq_o  out  1  level interrupt, high when valid=1 or ferr=1 or ovr=1.

Behaviour:

Reset (rst_i=0, asynchronous):
- ack_o=0, dat_o=0, irq_o=0.
- Data register = 0; status flags = 0.
- FSM = IDLE.
- Both RX synchroniser flops = 1.

Wishbone access:
- ack_o is stb_i registered: one clk_i of latency, high for exactly one cycle per strobe cycle.
- dat_o is registered on the same edge as ack_o and holds its value until the next access.
- Unmapped address: read returns 0x00, write is ignored, ack_o is still returned.

Status register (ADR_STATUS):
- Read value: {4'b0, busy, ferr, ovr, valid}.
- Write: ferr and ovr are write-1-to-clear via dat_i[2] and dat_i[1]; valid and busy are read-only.

Data register (ADR_DATA):
- Read returns the received byte and clears valid in the same cycle ack_o rises.
- Write is ignored.

RX path:
- Two-flop synchroniser on ch_in[RX_CH].
- A 16-bit bit counter and a 3-bit bit index drive the FSM.

FSM:
- IDLE: synchronised line=0 -> START, counter=0.
- START: at counter = CLKS_PER_BIT/2 - 1 (mid start bit):
  - line=0 -> DATA, counter=0, index=0;
  - line=1 -> IDLE (glitch rejected, no flag set).
- DATA: at counter = CLKS_PER_BIT-1, shift the line into bit[index], LSB first, and reset the counter. After index 7 -> STOP.
- STOP: at counter = CLKS_PER_BIT-1 (mid stop bit):
  - line=1: frame good. If valid=0, load the data register and set valid. If valid=1, discard the new byte, keep the old one and set ovr.
  - line=0: set ferr and discard the byte -> BRK.
  - Otherwise (good frame) -> IDLE. Return at mid stop bit allows back-to-back frames.
- BRK: wait for line=1 -> IDLE. This prevents a held-low line from producing repeated frames.
- busy = (state != IDLE).

Simultaneous events:
- Data read and a good frame completing in the same cycle: the new byte loads and valid stays 1; ovr is not set.
- Status write-1-to-clear and a flag set in the same cycle: the set wins.

Rules:
- Async reset mid-frame aborts the frame; no flag is set.
- Counter compare uses the full 16-bit width; no wrap-around inside a bit period.

Test Plan:
1. After reset, read STATUS -> 0x00, read DATA -> 0x00, and each access acks exactly 1 cycle after stb. Check ch_oe==6'h00 and irq_o=0.
2. CLKS_PER_BIT=8: drive frame 0xA5 on ch_in[1] -> STATUS=0x01, irq_o=1, DATA read=0xA5. Next STATUS read=0x00 and irq_o=0.
3. Send 0x0F then 0xF0 without reading -> STATUS=0x03, DATA=0x0F. Write STATUS 0x02 -> STATUS=0x01.
4. Frame 0x55 with stop bit driven 0 -> STATUS=0x0C while the line is low; after the line returns high, STATUS=0x04. valid stays 0; write 0x04 -> STATUS=0x00.
5. Low pulse of 3 clocks on idle line (less than CLKS_PER_BIT/2) -> no busy after 6 clocks, STATUS=0x00, no byte received.
6. Assert rst_i=0 mid data bit 4 of a frame, release, then send 0x3C -> DATA=0x3C, no ferr/ovr.
